sobel_scan_ctrl: RTL and testbench

SOBEL_SCAN_CTRL -- requirements
Module: sobel_scan_ctrl

---
 rtl/sobel_pkg.sv | 44 ++++
 rtl/sobel_addr_gen.sv | 36 +++
 rtl/sobel_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_sobel_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sobel_pkg                                                            |
// | Shared constants, FSM encoding and tap helpers for the Sobel block.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sobel_pkg;

  localparam int c_def_img_w  = 64;
  localparam int c_def_img_h  = 64;
  localparam int c_def_addr_w = 12;

  localparam logic [3:0] c_tap_last = 4'd8;

  typedef logic [2:0] state_t;

  localparam state_t c_st_idle  = 3'd0;
  localparam state_t c_st_fetch = 3'd1;
  localparam state_t c_st_drain = 3'd2;
  localparam state_t c_st_win   = 3'd3;
  localparam state_t c_st_res   = 3'd4;
  localparam state_t c_st_write = 3'd5;
  localparam state_t c_st_done  = 3'd6;

  // Row offset (tap/3) of a 3x3 tap index, without a divider.
  function automatic logic [1:0] tap_row_off(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd1, 4'd2: tap_row_off = 2'd0;
      4'd3, 4'd4, 4'd5: tap_row_off = 2'd1;
      default:          tap_row_off = 2'd2;
    endcase
  endfunction

  // Column offset (tap%3) of a 3x3 tap index.
  function automatic logic [1:0] tap_col_off(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd3, 4'd6: tap_col_off = 2'd0;
      4'd1, 4'd4, 4'd7: tap_col_off = 2'd1;
      default:          tap_col_off = 2'd2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sobel_addr_gen                                                       |
// | Row-major read address of a window tap and the window centre address.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W  = c_def_img_w,
  parameter int ADDR_W = c_def_addr_w
) (
  input  logic [ADDR_W-1:0] i_row,
  input  logic [ADDR_W-1:0] i_col,
  input  logic [3:0]        i_tap,
  output logic [ADDR_W-1:0] o_tap_addr,
  output logic [ADDR_W-1:0] o_ctr_addr
);

  localparam logic [ADDR_W-1:0] c_img_w = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] c_one   = ADDR_W'(1);

  logic [ADDR_W-1:0] w_tap_row;
  logic [ADDR_W-1:0] w_tap_col;

  // Centre is never on the border, so row-1 / col-1 cannot underflow.
  always_comb begin
    w_tap_row = i_row - c_one + ADDR_W'(tap_row_off(i_tap));
    w_tap_col = i_col - c_one + ADDR_W'(tap_col_off(i_tap));
  end

  assign o_tap_addr = w_tap_row * c_img_w + w_tap_col;
  assign o_ctr_addr = i_row * c_img_w + i_col;

endmodule
`default_nettype wire

// File: rtl/sobel_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sobel_scan_ctrl                                                      |
// | Scans interior pixels, fetches 3x3 windows, writes edge decisions.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W  = c_def_img_w,
  parameter int IMG_H  = c_def_img_h,
  parameter int ADDR_W = c_def_addr_w
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_data,
  input  logic              res_valid,
  input  logic              res_bit,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data
);

  localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_col_last = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] c_row_last = ADDR_W'(IMG_H - 2);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic [3:0]        r_tap;
  logic [3:0]        r_cap_idx;
  logic              r_cap_en;
  logic [71:0]       r_win;
  logic              r_res_bit;
  logic [ADDR_W-1:0] w_tap_addr;
  logic [ADDR_W-1:0] w_ctr_addr;
  logic              w_last_col;
  logic              w_last_row;

  assign w_last_col = (r_col == c_col_last);
  assign w_last_row = (r_row == c_row_last);

  sobel_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_row      (r_row),
    .i_col      (r_col),
    .i_tap      (r_tap),
    .o_tap_addr (w_tap_addr),
    .o_ctr_addr (w_ctr_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (start) w_next = c_st_fetch;
      c_st_fetch: if (r_tap == c_tap_last) w_next = c_st_drain;
      c_st_drain: w_next = c_st_win;
      c_st_win:   if (win_ready) w_next = c_st_res;
      c_st_res:   if (res_valid) w_next = c_st_write;
      c_st_write: w_next = (w_last_col && w_last_row) ? c_st_done : c_st_fetch;
      c_st_done:  w_next = c_st_idle;
      default:    w_next = c_st_idle;
    endcase
  end

  // Read data returns one cycle after the strobe, so the tap index is
  // delayed alongside it; the final capture lands in DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row     <= c_one;
      r_col     <= c_one;
      r_tap     <= 4'd0;
      r_cap_en  <= 1'b0;
      r_cap_idx <= 4'd0;
      r_win     <= '0;
      r_res_bit <= 1'b0;
    end else begin
      r_cap_en  <= (r_state == c_st_fetch);
      r_cap_idx <= r_tap;
      if (r_cap_en) begin
        r_win[{r_cap_idx, 3'b000} +: 8] <= rd_data;
      end
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_row <= c_one;
            r_col <= c_one;
            r_tap <= 4'd0;
          end
        end
        c_st_fetch: begin
          r_tap <= (r_tap == c_tap_last) ? 4'd0 : r_tap + 4'd1;
        end
        c_st_res: begin
          if (res_valid) r_res_bit <= res_bit;
        end
        c_st_write: begin
          if (!w_last_col) begin
            r_col <= r_col + c_one;
          end else begin
            r_col <= c_one;
            if (!w_last_row) r_row <= r_row + c_one;
          end
        end
        default: ;
      endcase
    end
  end

  // Addresses are forced to zero outside their strobe cycles.
  always_comb begin
    busy      = (r_state != c_st_idle) && (r_state != c_st_done);
    done      = (r_state == c_st_done);
    rd_en     = (r_state == c_st_fetch);
    win_valid = (r_state == c_st_win);
    wr_en     = (r_state == c_st_write);
    rd_addr   = rd_en ? w_tap_addr : '0;
    wr_addr   = wr_en ? w_ctr_addr : '0;
    win_data  = r_win;
    wr_data   = r_res_bit;
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sobel_scan_ctrl                                                   |
// | Directed scoreboard bench for a 4x4 image scan.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sobel_scan_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start, busy, done, rd_en, win_valid, win_ready;
  logic          res_valid, res_bit, wr_en, wr_data;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data;
  logic [7:0]    mem_q = 8'd0;
  logic [71:0]   win_data;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] exp_rd[$];
  logic [71:0]   exp_win[$];
  logic [AW:0]   exp_wr[$];
  logic          res_q[$];

  int cyc = 0;
  int wr_cnt = 0, done_cnt = 0, unexp = 0, rd_first = 0, win_first = 0;
  bit done_seen = 0, rd_seen = 0, win_seen = 0, pend_res = 0;

  sobel_scan_ctrl #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .res_valid (res_valid),
    .res_bit   (res_bit),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  // Pixel memory whose content equals its address, one cycle latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) mem_q <= {4'b0000, rd_addr};
  end
  assign rd_data = mem_q;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected reads, windows and writes for one full 4x4 scan.
  task automatic push_scan(input logic [3:0] bits);
    int i = 0;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        logic [71:0] w;
        w = '0;
        for (int t = 0; t < 9; t++) begin
          int a;
          a = (r - 1 + t / 3) * W + (c - 1 + t % 3);
          exp_rd.push_back(AW'(a));
          w[t*8 +: 8] = 8'(a);
        end
        exp_win.push_back(w);
        exp_wr.push_back({AW'(r * W + c), bits[i]});
        res_q.push_back(bits[i]);
        i++;
      end
    end
  endtask

  task automatic clear_stats();
    wr_cnt    = 0;
    done_cnt  = 0;
    unexp     = 0;
    done_seen = 0;
    rd_seen   = 0;
    win_seen  = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int n = 0;
    while (!done_seen && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 72'(done_seen), 72'(1));
  endtask

  task automatic end_checks(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, 72'(done_cnt), 72'(1));
    chk({tag, "_wr_cnt"}, 72'(wr_cnt), 72'(4));
    chk({tag, "_busy_after"}, 72'(busy), 72'(0));
    chk({tag, "_sb_left"}, 72'(exp_rd.size() + exp_win.size() + exp_wr.size()), 72'(0));
    chk({tag, "_unexpected"}, 72'(unexp), 72'(0));
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rd_en) begin
      if (!rd_seen) begin rd_first = cyc; rd_seen = 1; end
      if (exp_rd.size() == 0) unexp++;
      else chk("rd_addr", 72'(rd_addr), 72'(exp_rd.pop_front()));
    end
    if (win_valid && !win_seen) begin win_first = cyc; win_seen = 1; end
    if (win_valid && win_ready) begin
      if (exp_win.size() == 0) unexp++;
      else chk("win_data", win_data, exp_win.pop_front());
    end
    if (wr_en) begin
      wr_cnt++;
      if (exp_wr.size() == 0) unexp++;
      else chk("wr_addr_data", 72'({wr_addr, wr_data}), 72'(exp_wr.pop_front()));
    end
    if (done) begin
      done_cnt++;
      done_seen = 1;
      chk("busy_at_done", 72'(busy), 72'(0));
    end
  end

  // Datapath model: result one cycle after the window handshake.
  initial begin
    res_valid = 1'b0;
    res_bit   = 1'b0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (reset) begin
        pend_res = 0;
      end else begin
        if (pend_res) begin
          res_valid = 1'b1;
          res_bit   = (res_q.size() > 0) ? res_q.pop_front() : 1'b0;
          pend_res  = 0;
        end
        if (win_valid && win_ready) pend_res = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] held;
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    win_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 72'({busy, done, rd_en, win_valid, wr_en, wr_data}), 72'(0));
    chk("rst_addr", 72'({rd_addr, wr_addr}), 72'(0));
    chk("rst_win", win_data, 72'(0));
    reset = 1'b0;

    // Scan 1: free-running, alternating results, stray start while busy.
    clear_stats();
    push_scan(4'b0101);
    win_ready = 1'b1;
    pulse_start();
    chk("busy_after_start", 72'({busy, rd_en, rd_addr}), 72'({1'b1, 1'b1, 4'd0}));
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(400, "scan1_done");
    chk("fetch_latency", 72'(win_first - rd_first), 72'(10));
    end_checks("scan1");

    // Scan 2: hold off the first window for 7 cycles.
    clear_stats();
    push_scan(4'b0110);
    win_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!win_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_reach_win", 72'(win_valid), 72'(1));
    held = win_data;
    repeat (7) begin
      @(posedge clk); #1;
      chk("stall_ctrl", 72'({win_valid, rd_en, wr_en}), 72'(3'b100));
      chk("stall_data", win_data, held);
    end
    win_ready = 1'b1;
    wait_done(400, "scan2_done");
    end_checks("scan2");

    // Scan 3: reset during the second window fetch.
    clear_stats();
    push_scan(4'b1111);
    pulse_start();
    n = 0;
    while (wr_cnt < 1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_first_write", 72'(wr_cnt), 72'(1));
    chk("mid_in_fetch2", 72'({rd_en, rd_addr}), 72'({1'b1, 4'd1}));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", 72'({busy, done, rd_en, win_valid, wr_en, wr_data}), 72'(0));
    chk("mid_rst_addr", 72'({rd_addr, wr_addr}), 72'(0));
    chk("mid_rst_win", win_data, 72'(0));
    exp_rd.delete();
    exp_win.delete();
    exp_wr.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_no_activity", 72'({wr_cnt, unexp, 1'b0, busy}), 72'({32'd1, 32'd0, 1'b0, 1'b0}));

    // Scan 4: fresh start after the abandoned scan.
    clear_stats();
    push_scan(4'b1010);
    pulse_start();
    wait_done(400, "scan4_done");
    end_checks("scan4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
